// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst-read controller for a 1-cycle-latency block RAM with a skid-buffered output stream
module ram_burst_reader #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LEN_BITS  = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [LEN_BITS-1:0]  burst_len,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_wdata,
    input  logic [DATA_BITS-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [LEN_BITS-1:0]   remaining;
    logic                  inflight;
    logic                  zero_done;
    logic                  drain_done;
    logic [DATA_BITS-1:0]  fifo_mem [2];
    logic                  fifo_wp;
    logic                  fifo_rp;
    logic [1:0]            fifo_cnt;
    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic                  room;
    logic                  issue;

    // Words already owed to the stream are those buffered plus the one in the RAM pipe;
    // a new read is only safe if the skid buffer can still take it after this cycle's pop.
    assign pop       = rd_valid & rd_ready;
    assign push      = inflight;
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign room      = occupancy < (3'd2 + {2'b00, pop});
    assign issue     = (state == S_RUN) && (remaining != '0) && !wr_valid && room;

    assign busy     = (state != S_IDLE);
    assign done     = drain_done | zero_done;
    assign rd_valid = (fifo_cnt != 2'd0);
    assign rd_data  = fifo_mem[fifo_rp];
    assign wr_ready = 1'b1;

    // RAM port driver: writes pre-empt reads; everything is held at zero while in reset
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst_n && wr_valid) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end else if (rst_n && issue) begin
            ram_en   = 1'b1;
            ram_addr = rd_ptr;
        end
    end

    // Next-state logic; the drain-complete done pulse is combinational with the last DRAIN cycle
    always_comb begin
        state_nx   = state;
        drain_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (burst_len != '0)) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (remaining == LEN_BITS'(1))) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight && (fifo_cnt == 2'd0)) begin
                    drain_done = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Burst bookkeeping: address pointer, words left to issue, read-pipe flag, zero-length done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            inflight  <= issue;
            zero_done <= (state == S_IDLE) && start && (burst_len == '0);
            if ((state == S_IDLE) && start && (burst_len != '0)) begin
                rd_ptr    <= base_addr;
                remaining <= burst_len;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + ADDR_BITS'(1);
                remaining <= remaining - LEN_BITS'(1);
            end
        end
    end

    // Two-entry skid FIFO catching RAM read data; head is registered storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wp] <= ram_rdata;
                fifo_wp           <= ~fifo_wp;
            end
            if (pop) begin
                fifo_rp <= ~fifo_rp;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - randomized self-checking bench for ram_burst_reader
module tb_ram_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  burst_len = '0;
    logic        busy, done, rd_valid;
    logic        rd_ready = 1'b0;
    logic [15:0] rd_data;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    ram_burst_reader #(.ADDR_BITS(8), .DATA_BITS(16), .LEN_BITS(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .burst_len(burst_len),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: single port, registered read data
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram[ram_addr];
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    logic [15:0] exp_q[$];
    logic [7:0]  addr_q[$];
    logic [15:0] got_q[$];
    logic [15:0] pre_q[$];
    bit          preload = 0;
    int          outstanding = 0;
    int          done_due = -1;
    int          busy_from = -1;
    int          busy_to = -1;
    bit          active = 0;
    int          start_cyc = 0, first_pop = -1, last_pop = -1, done_cyc = -1;
    int          n_done = 0, done_mark = 0;
    bit          hold_v = 0;
    logic [15:0] hold_d = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, expv);
        end
    endtask

    function automatic bit exp_busy();
        return (busy_from >= 0) && (cyc >= busy_from) && (cyc <= busy_to);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: one check pass per cycle, on the falling edge
    initial forever begin
        bit pop;
        logic [7:0] a8;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete(); addr_q.delete();
            outstanding = 0; done_due = -1; busy_from = -1; busy_to = -1;
            active = 0; hold_v = 0;
        end else begin
            pop = rd_valid && rd_ready;
            chk("busy", busy, exp_busy());
            chk("done", done, cyc == done_due);
            if (done) begin n_done++; done_cyc = cyc; end
            if (start && !exp_busy()) begin
                start_cyc = cyc; first_pop = -1; last_pop = -1; got_q.delete();
                if (burst_len == 0) begin
                    done_due = cyc + 1;
                end else begin
                    busy_from = cyc + 1; busy_to = 32'h7fffffff; active = 1;
                    for (int k = 0; k < int'(burst_len); k++) begin
                        a8 = 8'(int'(base_addr) + k);
                        addr_q.push_back(a8);
                        exp_q.push_back(preload ? pre_q[k] : ram[a8]);
                    end
                end
            end
            if (wr_valid) begin
                chk("write_port", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, wr_addr, wr_data});
            end else if (ram_en) begin
                chk("read_we", ram_we, 1'b0);
                if (addr_q.size() == 0) chk("extra_read", 1'b1, 1'b0);
                else chk("read_addr", ram_addr, addr_q.pop_front());
                chk("room", (outstanding + 1 - int'(pop)) <= 2, 1'b1);
                outstanding++;
            end
            if (hold_v) chk("stall_stable", {rd_valid, rd_data}, {1'b1, hold_d});
            if (rd_valid && exp_q.size() == 0) begin
                chk("extra_word", 1'b1, 1'b0);
            end else if (pop) begin
                chk("rd_data", rd_data, exp_q.pop_front());
                got_q.push_back(rd_data);
                outstanding--;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                if (exp_q.size() == 0 && active) begin
                    done_due = cyc + 1; busy_to = cyc + 1; active = 0;
                end
            end
            hold_v = rd_valid && !rd_ready;
            hold_d = rd_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] b, input logic [8:0] l);
        done_mark = n_done;
        start = 1'b1; base_addr = b; burst_len = l; wr_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1,0,1; 2: random ready plus writes outside the burst
    task automatic run_until_done(input int budget, input int mode, input logic [7:0] b, input int len);
        int k = 0;
        bit pat [6] = '{1, 0, 0, 1, 0, 1};
        while (n_done == done_mark && k < budget) begin
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = pat[k % 6];
                default: begin
                    rd_ready = ($urandom % 3) != 0;
                    wr_valid = (len < 256) && (($urandom % 4) == 0);
                    wr_addr  = 8'(int'(b) + len + int'($urandom_range(0, 255 - len)));
                    wr_data  = 16'($urandom);
                end
            endcase
            step();
            k++;
        end
        wr_valid = 1'b0;
        chk("done_timeout", n_done > done_mark, 1'b1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) ram[i] = 16'(16'h100 + i);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, rd_valid, ram_en, ram_we, ram_addr, ram_wdata}, '0);
        chk("wr_ready_tied", wr_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // Basic burst, full throughput
        rd_ready = 1'b1;
        start_burst(8'd4, 9'd8);
        run_until_done(100, 0, 8'd0, 0);
        chk("t1_first_pop", first_pop, start_cyc + 3);
        chk("t1_last_pop", last_pop, start_cyc + 10);
        chk("t1_done_cyc", done_cyc, start_cyc + 11);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_count", got_q.size(), 8);
        chk("t1_word0", got_q[0], 16'h104);
        chk("t1_word7", got_q[7], 16'h10B);
        step();

        // Address wrap
        start_burst(8'd254, 9'd4);
        run_until_done(100, 0, 8'd0, 0);
        chk("t2_w0", got_q[0], 16'h1FE);
        chk("t2_w1", got_q[1], 16'h1FF);
        chk("t2_w2", got_q[2], 16'h100);
        chk("t2_w3", got_q[3], 16'h101);
        step();

        // Backpressure pattern
        start_burst(8'd40, 9'd6);
        run_until_done(200, 1, 8'd0, 0);
        chk("t3_count", got_q.size(), 6);
        chk("t3_last", got_q[5], 16'h12D);
        rd_ready = 1'b1;
        step();

        // Write priority inside a burst
        pre_q = '{16'h100, 16'h101, 16'h102, 16'hBEEF};
        preload = 1;
        start_burst(8'd0, 9'd4);
        preload = 0;
        step();
        wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 16'hBEEF;
        step();
        step();
        wr_valid = 1'b0;
        run_until_done(100, 0, 8'd0, 0);
        chk("t4_word3", got_q[3], 16'hBEEF);
        step();

        // Zero-length burst
        start_burst(8'd9, 9'd0);
        run_until_done(10, 0, 8'd0, 0);
        chk("t5_zero_busy", busy, 1'b0);
        step();

        // Start while busy is ignored
        rd_ready = 1'b0;
        start_burst(8'd100, 9'd6);
        repeat (3) step();
        start = 1'b1; base_addr = 8'd50; burst_len = 9'd3;
        step();
        start = 1'b0;
        run_until_done(100, 0, 8'd0, 0);
        repeat (10) step();
        chk("t6_count", got_q.size(), 6);

        // Reset mid-burst, then a clean burst
        start_burst(8'd10, 9'd10);
        k = 0;
        while (got_q.size() < 3 && k < 50) begin step(); k++; end
        chk("t7_three_words", got_q.size() >= 3, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wr_valid = 1'b1; wr_addr = 8'd7; wr_data = 16'h1234;
        #1;
        chk("t7_async_reset", {busy, done, rd_valid, ram_en, ram_we, ram_addr, ram_wdata}, '0);
        repeat (2) step();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("t7_busy_post", busy, 1'b0);
        start_burst(8'd200, 9'd5);
        run_until_done(100, 0, 8'd0, 0);
        chk("t7_count", got_q.size(), 5);
        chk("t7_first", got_q[0], 16'h1C8);
        step();

        // Randomized bursts with random backpressure and unrelated writes
        for (int n = 0; n < 25; n++) begin
            logic [7:0] b;
            int l;
            b = 8'($urandom);
            l = (n == 0) ? 256 : int'($urandom_range(1, 24));
            start_burst(b, 9'(l));
            run_until_done(3000, 2, b, l);
            chk("rand_count", got_q.size(), l);
            rd_ready = 1'b1;
            repeat (2) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
